// File: rtl/datamover_cmd_scheduler.sv
// datamover_cmd_scheduler
//   Round-robin sharing of one AXI DataMover command/status channel pair among
//   NUM_REQ requesters. Builds the 72-bit command with tag = requester index,
//   caps commands in flight, and routes returned statuses back by tag.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | command register empty; may grant one requester per cycle
//   ST_ISSUE | command register loaded; TVALID high until TREADY
module datamover_cmd_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int REQ_IDX_W       = 2,
   parameter int MAX_OUTSTANDING = 8,
   parameter int CMD_W           = 72,
   parameter int STS_W           = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*23-1:0]   req_size,
   output logic                    M_AXIS_CMD_TVALID,
   input  logic                    M_AXIS_CMD_TREADY,
   output logic [CMD_W-1:0]        M_AXIS_CMD_TDATA,
   input  logic                    S_AXIS_STS_TVALID,
   output logic                    S_AXIS_STS_TREADY,
   input  logic [STS_W-1:0]        S_AXIS_STS_TDATA,
   output logic [NUM_REQ-1:0]      sts_valid,
   input  logic [NUM_REQ-1:0]      sts_ready,
   output logic [STS_W-1:0]        sts_data,
   output logic [3:0]              outstanding,
   output logic [7:0]              err_count
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   localparam logic [REQ_IDX_W-1:0] LAST_IDX = REQ_IDX_W'(NUM_REQ - 1);
   localparam logic [3:0]           MAX_OUT  = 4'(MAX_OUTSTANDING);
   localparam logic [4:0]           NUM_TAGS = 5'(NUM_REQ);

   state_t                 state_q, state_d;
   logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CMD_W-1:0]       cmd_q, cmd_d;
   logic [3:0]             outstanding_q, outstanding_d;
   logic [7:0]             err_q, err_d;

   logic                   grant_found;
   logic [REQ_IDX_W-1:0]   grant_idx;
   logic [REQ_IDX_W-1:0]   scan_idx;
   logic                   grant;
   logic [31:0]            sel_addr;
   logic [22:0]            sel_size;

   logic [3:0]             sts_tag;
   logic                   sts_tag_ok;
   logic [REQ_IDX_W-1:0]   sts_idx;
   logic                   sts_tready;
   logic                   sts_hs;
   logic                   bad_sts;

   logic                   cmd_hs;
   logic                   zero_drop;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = REQ_IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Mux the winner's job fields out of the flattened request buses.
   always_comb begin
      sel_addr = '0;
      sel_size = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (REQ_IDX_W'(k) == grant_idx) begin
            sel_addr = req_addr[k*32 +: 32];
            sel_size = req_size[k*23 +: 23];
         end
      end
   end

   // A grant needs an empty command register and a free in-flight slot.
   always_comb begin
      grant     = (state_q == ST_IDLE) && (outstanding_q < MAX_OUT) && grant_found;
      req_ready = '0;
      if (grant) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Status routing by tag; unknown tags are swallowed and counted as errors.
   always_comb begin
      sts_tag    = S_AXIS_STS_TDATA[3:0];
      sts_tag_ok = ({1'b0, sts_tag} < NUM_TAGS);
      sts_idx    = sts_tag[REQ_IDX_W-1:0];
      sts_valid  = '0;
      sts_tready = 1'b1;
      if (sts_tag_ok) begin
         sts_valid[sts_idx] = S_AXIS_STS_TVALID;
         sts_tready         = sts_ready[sts_idx];
      end
      sts_hs  = S_AXIS_STS_TVALID && sts_tready;
      bad_sts = sts_hs && !sts_tag_ok;
   end

   // Next-state and command-register logic for the issue FSM.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cmd_d     = cmd_q;
      zero_drop = 1'b0;
      cmd_hs    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
               if (sel_size == '0) begin
                  zero_drop = 1'b1;
               end else begin
                  cmd_d   = CMD_W'({4'h0, 4'(grant_idx), sel_addr,
                                    1'b0, 1'b1, 6'h00, 1'b0, sel_size});
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (M_AXIS_CMD_TREADY) begin
               cmd_hs  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // In-flight count: up on command handshake, down on any status handshake,
   // floored at zero so statuses left over from before a reset cannot wrap it.
   always_comb begin
      outstanding_d = outstanding_q;
      if (cmd_hs && !sts_hs) begin
         outstanding_d = outstanding_q + 4'd1;
      end else if (sts_hs && !cmd_hs && (outstanding_q != 4'd0)) begin
         outstanding_d = outstanding_q - 4'd1;
      end
   end

   // Error counter; a zero-size drop and a bad-tag status can land together.
   always_comb begin
      logic [8:0] err_sum;
      err_sum = {1'b0, err_q} + 9'(zero_drop) + 9'(bad_sts);
      err_d   = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         cmd_q         <= '0;
         outstanding_q <= '0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         cmd_q         <= cmd_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   assign M_AXIS_CMD_TVALID = (state_q == ST_ISSUE);
   assign M_AXIS_CMD_TDATA  = cmd_q;
   assign S_AXIS_STS_TREADY = sts_tready;
   assign sts_data          = S_AXIS_STS_TDATA;
   assign outstanding       = outstanding_q;
   assign err_count         = err_q;

endmodule

// File: tb/tb_datamover_cmd_scheduler.sv
// Bench for datamover_cmd_scheduler: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model of the scheduling rules.
module tb_datamover_cmd_scheduler;

   localparam int N    = 4;
   localparam int MAXO = 8;

   logic             clk = 1'b0;
   logic             rstn;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*32-1:0]  req_addr;
   logic [N*23-1:0]  req_size;
   logic             cmd_tvalid;
   logic             cmd_tready;
   logic [71:0]      cmd_tdata;
   logic             sts_tvalid;
   logic             sts_tready;
   logic [7:0]       sts_tdata;
   logic [N-1:0]     sts_valid;
   logic [N-1:0]     sts_ready;
   logic [7:0]       sts_data;
   logic [3:0]       outstanding;
   logic [7:0]       err_count;

   logic [31:0]      addr_a [N];
   logic [22:0]      size_a [N];

   int               n_tests = 0;
   int               n_fail  = 0;

   // model state
   bit               m_valid = 0;
   bit               m_busy;
   bit               m_fresh;
   logic [71:0]      m_cmd;
   int               m_out;
   int               m_err;
   int               m_rr;
   logic [N-1:0]     m_gnt;
   int               hs_count;
   int               tag_q [$];

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         req_addr[k*32 +: 32] = addr_a[k];
         req_size[k*23 +: 23] = size_a[k];
      end
   end

   datamover_cmd_scheduler #(
      .NUM_REQ(N), .REQ_IDX_W(2), .MAX_OUTSTANDING(MAXO), .CMD_W(72), .STS_W(8)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_addr          (req_addr),
      .req_size          (req_size),
      .M_AXIS_CMD_TVALID (cmd_tvalid),
      .M_AXIS_CMD_TREADY (cmd_tready),
      .M_AXIS_CMD_TDATA  (cmd_tdata),
      .S_AXIS_STS_TVALID (sts_tvalid),
      .S_AXIS_STS_TREADY (sts_tready),
      .S_AXIS_STS_TDATA  (sts_tdata),
      .sts_valid         (sts_valid),
      .sts_ready         (sts_ready),
      .sts_data          (sts_data),
      .outstanding       (outstanding),
      .err_count         (err_count)
   );

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [71:0] build_cmd(input int tag, input logic [31:0] a,
                                             input logic [22:0] s);
      return {4'h0, 4'(tag), a, 1'b0, 1'b1, 6'h00, 1'b0, s};
   endfunction

   // Per-cycle compare against the model, then advance the model over the edge.
   task automatic model_cycle();
      int          w;
      int          t;
      logic [N-1:0] e_rdy;
      logic [N-1:0] e_sv;
      logic        e_str;
      bit          c_hs;
      bit          s_hs;
      int          inc;
      w = -1;
      if (!m_busy && m_out < MAXO) begin
         for (int i = 0; i < N; i++) begin
            int j;
            j = (m_rr + i) % N;
            if (w < 0 && ((req_valid >> j) & N'(1)) != '0) w = j;
         end
      end
      e_rdy = '0;
      if (w >= 0) e_rdy = N'(1) << w;
      t = int'(sts_tdata[3:0]);
      if (t < N) begin
         e_sv  = sts_tvalid ? (N'(1) << t) : '0;
         e_str = ((sts_ready >> t) & N'(1)) != '0;
      end else begin
         e_sv  = '0;
         e_str = 1'b1;
      end

      if (m_valid) begin
         chk("req_ready",   72'(req_ready),   72'(e_rdy));
         chk("cmd_tvalid",  72'(cmd_tvalid),  72'(m_busy));
         if (m_busy)       chk("cmd_tdata", cmd_tdata, m_cmd);
         else if (m_fresh) chk("cmd_tdata_rst", cmd_tdata, 72'h0);
         chk("sts_tready",  72'(sts_tready),  72'(e_str));
         chk("sts_valid",   72'(sts_valid),   72'(e_sv));
         chk("sts_data",    72'(sts_data),    72'(sts_tdata));
         chk("outstanding", 72'(outstanding), 72'(m_out));
         chk("err_count",   72'(err_count),   72'(m_err));
         if (rstn && cmd_tvalid && cmd_tready) begin
            hs_count++;
            tag_q.push_back(int'(cmd_tdata[67:64]));
         end
      end

      if (!rstn) begin
         m_valid = 1;
         m_busy  = 0;
         m_fresh = 1;
         m_cmd   = '0;
         m_out   = 0;
         m_err   = 0;
         m_rr    = 0;
         m_gnt   = '0;
      end else if (m_valid) begin
         c_hs  = m_busy && cmd_tready;
         s_hs  = sts_tvalid && e_str;
         m_gnt = e_rdy;
         inc   = 0;
         if (c_hs) m_busy = 0;
         if (w >= 0) begin
            m_rr = (w + 1) % N;
            if (size_a[w] == '0) inc++;
            else begin
               m_busy  = 1;
               m_fresh = 0;
               m_cmd   = build_cmd(w, addr_a[w], size_a[w]);
            end
         end
         if (c_hs && !s_hs) m_out++;
         else if (s_hs && !c_hs && m_out > 0) m_out--;
         if (s_hs && t >= N) inc++;
         m_err = m_err + inc;
         if (m_err > 255) m_err = 255;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rstn       = 1'b0;
      req_valid  = '0;
      cmd_tready = 1'b0;
      sts_tvalid = 1'b0;
      sts_tdata  = '0;
      sts_ready  = '1;
      step();
      step();
      rstn = 1'b1;
   endtask

   initial begin
      int exp_order [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < N; k++) begin
         addr_a[k] = '0;
         size_a[k] = '0;
      end
      reset_dut();
      chk("rst_outstanding", 72'(outstanding), 72'd0);
      chk("rst_err",         72'(err_count),   72'd0);
      chk("rst_tvalid",      72'(cmd_tvalid),  72'd0);
      chk("rst_tdata",       cmd_tdata,        72'h0);
      chk("rst_req_ready",   72'(req_ready),   72'd0);

      // single request, one-cycle latency to TVALID
      addr_a[0] = 32'h1000_0000;
      size_a[0] = 23'h100;
      req_valid = 4'b0001;
      cmd_tready = 1'b1;
      #1;
      chk("t1_req_ready", 72'(req_ready), 72'h1);
      step();
      req_valid = '0;
      chk("t1_tvalid", 72'(cmd_tvalid), 72'd1);
      chk("t1_tdata",  cmd_tdata, 72'h00_1000_0000_4000_0100);
      step();
      chk("t1_outstanding", 72'(outstanding), 72'd1);
      chk("t1_tvalid_done", 72'(cmd_tvalid),  72'd0);

      // round-robin order with every requester asking
      reset_dut();
      for (int k = 0; k < N; k++) begin
         addr_a[k] = 32'h2000_0000 + 32'(k) * 32'h100;
         size_a[k] = 23'h40 * 23'(k + 1);
      end
      hs_count = 0;
      tag_q.delete();
      req_valid  = '1;
      cmd_tready = 1'b1;
      repeat (10) step();
      chk("t2_issue_count", 72'(hs_count), 72'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < tag_q.size()) chk("t2_tag_order", 72'(tag_q[i]), 72'(exp_order[i]));
         else                  chk("t2_tag_missing", 72'(-1), 72'(exp_order[i]));
      end
      chk("t2_outstanding", 72'(outstanding), 72'd5);

      // in-flight cap, then one status frees one slot
      reset_dut();
      hs_count   = 0;
      req_valid  = '1;
      cmd_tready = 1'b1;
      repeat (30) step();
      chk("t3_issue_count", 72'(hs_count), 72'd8);
      chk("t3_outstanding", 72'(outstanding), 72'd8);
      #1;
      chk("t3_blocked", 72'(req_ready), 72'd0);
      sts_tdata  = 8'h02;
      sts_tvalid = 1'b1;
      sts_ready  = '1;
      step();
      sts_tvalid = 1'b0;
      repeat (4) step();
      chk("t3_refill_count", 72'(hs_count), 72'd9);
      chk("t3_refill_out",   72'(outstanding), 72'd8);
      req_valid = '0;

      // status backpressure, then a bad tag
      reset_dut();
      sts_tdata  = 8'h03;
      sts_tvalid = 1'b1;
      sts_ready  = 4'b0111;
      repeat (5) begin
         #1;
         chk("t4_stall_tready", 72'(sts_tready), 72'd0);
         chk("t4_stall_valid",  72'(sts_valid),  72'h8);
         step();
      end
      sts_ready = '1;
      #1;
      chk("t4_release_tready", 72'(sts_tready), 72'd1);
      step();
      sts_tdata = 8'h09;
      #1;
      chk("t4_badtag_tready", 72'(sts_tready), 72'd1);
      chk("t4_badtag_valid",  72'(sts_valid),  72'd0);
      step();
      sts_tvalid = 1'b0;
      chk("t4_err", 72'(err_count), 72'd1);

      // zero-size job is granted and dropped, next requester follows
      reset_dut();
      size_a[1]  = 23'h0;
      size_a[2]  = 23'h80;
      addr_a[2]  = 32'h3000_0040;
      req_valid  = 4'b0110;
      cmd_tready = 1'b1;
      #1;
      chk("t5_zero_grant", 72'(req_ready), 72'h2);
      step();
      chk("t5_err",       72'(err_count),  72'd1);
      chk("t5_no_tvalid", 72'(cmd_tvalid), 72'd0);
      req_valid = 4'b0100;
      #1;
      chk("t5_next_grant", 72'(req_ready), 72'h4);
      step();
      chk("t5_tvalid", 72'(cmd_tvalid), 72'd1);
      chk("t5_tag",    72'(cmd_tdata[67:64]), 72'd2);
      req_valid = '0;
      step();

      // reset while a command is waiting, then a stale status
      reset_dut();
      addr_a[0]  = 32'hA000_0000;
      size_a[0]  = 23'h10;
      req_valid  = 4'b0001;
      cmd_tready = 1'b1;
      repeat (6) step();
      chk("t6_outstanding", 72'(outstanding), 72'd3);
      cmd_tready = 1'b0;
      step();
      chk("t6_in_issue", 72'(cmd_tvalid), 72'd1);
      rstn = 1'b0;
      step();
      chk("t6_rst_tvalid", 72'(cmd_tvalid),  72'd0);
      chk("t6_rst_out",    72'(outstanding), 72'd0);
      rstn       = 1'b1;
      req_valid  = '0;
      sts_tdata  = 8'h00;
      sts_tvalid = 1'b1;
      sts_ready  = '1;
      #1;
      chk("t6_stale_tready", 72'(sts_tready), 72'd1);
      step();
      sts_tvalid = 1'b0;
      chk("t6_no_underflow", 72'(outstanding), 72'd0);

      // randomized traffic, model checks every cycle
      reset_dut();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (req_valid[k] && m_gnt[k]) req_valid[k] = 1'b0;
            if (!req_valid[k]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid[k] = 1'b1;
                  addr_a[k]    = $urandom;
                  size_a[k]    = ($urandom_range(0, 15) == 0) ? 23'h0
                                 : 23'($urandom_range(1, 8_000_000));
               end
            end else if ($urandom_range(0, 31) == 0) begin
               req_valid[k] = 1'b0;
            end
         end
         cmd_tready = ($urandom_range(0, 3) != 0);
         sts_tvalid = ($urandom_range(0, 2) == 0);
         sts_tdata  = {4'($urandom),
                       ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                   : 4'($urandom_range(0, 3))};
         sts_ready  = 4'($urandom);
         rstn       = ($urandom_range(0, 499) != 0);
         step();
      end

      // err_count saturation on a flood of bad-tag statuses
      reset_dut();
      sts_tdata  = 8'h0F;
      sts_tvalid = 1'b1;
      repeat (300) step();
      sts_tvalid = 1'b0;
      chk("sat_err", 72'(err_count), 72'd255);
      chk("sat_out", 72'(outstanding), 72'd0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
